reverse_delay: RTL

REVERSE_DELAY -- requirements
Module: reverse_delay

---
 rtl/reverse_delay.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/reverse_delay.sv
// Segment reverser: each SEG_LEN-sample block is replayed backwards one segment later.
// Optional REVERSE_DELAY_DRY_MIX_EN averages the dry input with the reversed (wet) signal.
module reverse_delay #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15,
    parameter int SEG_LEN    = 8192
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic                  x_valid,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  y_valid,
    output logic                  bank
);

    localparam logic [ADDR_WIDTH-1:0] SEG  = ADDR_WIDTH'(SEG_LEN);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SEG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_e;

    typedef enum logic [1:0] {
        M_BYP,
        M_PRIME,
        M_RUN
    } mode_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    bank_q, bank_d;

    logic                    v1_q;
    mode_e                   mode1_q;
    logic [DATA_WIDTH-1:0]   dry1_q;
    logic [DATA_WIDTH-1:0]   wet_q;

    logic [DATA_WIDTH-1:0]   y_q, y_d;
    logic                    yv_q;

    logic [DATA_WIDTH-1:0]   mem [2*SEG_LEN];

    logic                    accept;
    logic                    seg_end;
    mode_e                   mode_c;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    assign accept  = en & x_valid;
    assign seg_end = accept & (idx_q == LAST);

    // An accept while still IDLE already belongs to the first (priming) segment.
    always_comb begin
        mode_c = M_PRIME;
        if (!en) begin
            mode_c = M_BYP;
        end else if (state_q == RUN) begin
            mode_c = M_RUN;
        end
    end

    always_comb begin
        wr_addr = idx_q;
        rd_addr = SEG + (LAST - idx_q);
        if (bank_q) begin
            wr_addr = SEG + idx_q;
            rd_addr = LAST - idx_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bank_d  = bank_q;
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            bank_d  = 1'b0;
        end else begin
            if (state_q == IDLE) begin
                state_d = PRIME;
            end
            if (seg_end) begin
                idx_d   = '0;
                bank_d  = ~bank_q;
                state_d = RUN;
            end else if (accept) begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bank_q  <= bank_d;
        end
    end

    // Buffer is never cleared; the priming segment masks whatever it holds.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wr_addr] <= x;
            wet_q        <= mem[rd_addr];
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            v1_q    <= 1'b0;
            mode1_q <= M_BYP;
            dry1_q  <= '0;
        end else begin
            v1_q <= x_valid;
            if (x_valid) begin
                mode1_q <= mode_c;
                dry1_q  <= x;
            end
        end
    end

`ifdef REVERSE_DELAY_DRY_MIX_EN
    logic [DATA_WIDTH:0]   mix_sum;
    logic [DATA_WIDTH-1:0] mix_run;
    logic [DATA_WIDTH-1:0] mix_prime;

    assign mix_sum   = {dry1_q[DATA_WIDTH-1], dry1_q}
                     + {wet_q[DATA_WIDTH-1], wet_q};
    assign mix_run   = mix_sum[DATA_WIDTH:1];
    assign mix_prime = {dry1_q[DATA_WIDTH-1], dry1_q[DATA_WIDTH-1:1]};
`else
    logic [DATA_WIDTH-1:0] mix_run;
    logic [DATA_WIDTH-1:0] mix_prime;

    assign mix_run   = wet_q;
    assign mix_prime = '0;
`endif

    always_comb begin
        y_d = dry1_q;
        unique case (mode1_q)
            M_BYP:   y_d = dry1_q;
            M_PRIME: y_d = mix_prime;
            M_RUN:   y_d = mix_run;
            default: y_d = dry1_q;
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            y_q  <= '0;
            yv_q <= 1'b0;
        end else begin
            yv_q <= v1_q;
            if (v1_q) begin
                y_q <= y_d;
            end
        end
    end

    assign y       = y_q;
    assign y_valid = yv_q;
    assign bank    = bank_q;

endmodule
